sht40_sequencer: RTL and testbench



---
 rtl/sht40_pkg.sv | 24 ++
 rtl/sht40_sequencer_if.sv | 25 ++
 rtl/sht_crc8.sv | 15 +
 rtl/sht40_sequencer.sv | 136 +++++++++++++
 tb/tb_sht40_sequencer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sht40_pkg.sv
// Shared constants, FSM encoding and error codes for the SHT40 measurement sequencer.
package sht40_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD_REQ,
        S_CMD_WAIT,
        S_MEAS_WAIT,
        S_RD_REQ,
        S_RD,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] CMD_MEASURE = 8'hFD;
    localparam logic [7:0] CRC_POLY    = 8'h31;
    localparam logic [7:0] CRC_INIT    = 8'hFF;
    localparam int         READ_BYTES  = 6;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CRC     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/sht40_sequencer_if.sv
// Sequencer <-> i2c_master link. "master" is the sequencer end (it issues requests),
// "slave" is the i2c_master end (it reports frame acks and received bytes).
interface sht40_sequencer_if;
    logic       Frames_Read;
    logic [7:0] Data_Received;
    logic [3:0] Output_Received_Counter;
    logic       Processor_Ready;
    logic       Read_Not_Write;
    logic [7:0] Command_Data_Frames;
    logic [2:0] I2c_Writes;
    logic [3:0] SHT_Reads;
    logic       CRC_Error;

    modport master (
        input  Frames_Read, Data_Received, Output_Received_Counter,
        output Processor_Ready, Read_Not_Write, Command_Data_Frames,
        output I2c_Writes, SHT_Reads, CRC_Error
    );

    modport slave (
        output Frames_Read, Data_Received, Output_Received_Counter,
        input  Processor_Ready, Read_Not_Write, Command_Data_Frames,
        input  I2c_Writes, SHT_Reads, CRC_Error
    );
endinterface

// File: rtl/sht_crc8.sv
// One-byte step of the Sensirion CRC-8 (poly 0x31, MSB first); purely combinational.
module sht_crc8
    import sht40_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);
    always_comb begin
        crc_out = crc_in ^ data_in;
        for (int i = 0; i < 8; i++) begin
            crc_out = crc_out[7] ? ({crc_out[6:0], 1'b0} ^ CRC_POLY) : {crc_out[6:0], 1'b0};
        end
    end
endmodule

// File: rtl/sht40_sequencer.sv
// One SHT40 measurement per Start: command write, conversion wait, 6-byte read with CRC check.
// Moore-decoded outputs; a watchdog aborts if the master stalls in an ack/byte wait.
module sht40_sequencer
    import sht40_pkg::*;
#(
    parameter int unsigned MEAS_WAIT_CYCLES = 20000,
    parameter int unsigned TIMEOUT_CYCLES   = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Start,
    sht40_sequencer_if.master i2c,
    output logic              Busy,
    output logic [15:0]       Temp_Raw,
    output logic [15:0]       Hum_Raw,
    output logic              Data_Valid,
    output logic [1:0]        Error_Flag
);
    localparam int unsigned TMAX   = (TIMEOUT_CYCLES > MEAS_WAIT_CYCLES) ? TIMEOUT_CYCLES : MEAS_WAIT_CYCLES;
    localparam int          TW     = $clog2(TMAX + 1);
    localparam logic [2:0]  K_LAST = 3'(READ_BYTES - 1);

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q;
    logic            frame_seen_q;
    logic [2:0]      k_q;
    logic [7:0]      crc_q, crc_next;
    logic [31:0]     shift_q;
    logic [3:0]      cnt_q;
    logic [1:0]      err_cause;
    logic            byte_evt, crc_bad, timeout_hit, meas_hit, activity;

    assign byte_evt    = (i2c.Output_Received_Counter != cnt_q);
    assign crc_bad     = ((k_q == 3'd2) || (k_q == K_LAST)) && (i2c.Data_Received != crc_q);
    assign timeout_hit = (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign meas_hit    = (timer_q == TW'(MEAS_WAIT_CYCLES - 1));
    assign activity    = ((state_q == S_CMD_WAIT) && i2c.Frames_Read) || ((state_q == S_RD) && byte_evt);

    assign i2c.Command_Data_Frames = CMD_MEASURE;
    assign i2c.I2c_Writes          = 3'd1;
    assign i2c.SHT_Reads           = 4'(READ_BYTES - 1);

    sht_crc8 u_crc (
        .crc_in  (crc_q),
        .data_in (i2c.Data_Received),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d             = state_q;
        err_cause           = ERR_NONE;
        i2c.Processor_Ready = (state_q == S_CMD_REQ) || (state_q == S_RD_REQ);
        i2c.Read_Not_Write  = (state_q == S_RD_REQ);
        i2c.CRC_Error       = (state_q == S_ERR) && (Error_Flag == ERR_CRC);
        Busy                = (state_q != S_IDLE);
        Data_Valid          = (state_q == S_DONE);
        case (state_q)
            S_IDLE:      if (Start) state_d = S_CMD_REQ;
            S_CMD_REQ:   state_d = S_CMD_WAIT;
            S_CMD_WAIT: begin
                // first ack is the address, second is the command byte
                if (i2c.Frames_Read) begin
                    if (frame_seen_q) state_d = S_MEAS_WAIT;
                end else if (timeout_hit) begin
                    state_d   = S_ERR;
                    err_cause = ERR_TIMEOUT;
                end
            end
            S_MEAS_WAIT: if (meas_hit) state_d = S_RD_REQ;
            S_RD_REQ:    state_d = S_RD;
            S_RD: begin
                if (byte_evt) begin
                    if (crc_bad) begin
                        state_d   = S_ERR;
                        err_cause = ERR_CRC;
                    end else if (k_q == K_LAST) begin
                        state_d = S_DONE;
                    end
                end else if (timeout_hit) begin
                    state_d   = S_ERR;
                    err_cause = ERR_TIMEOUT;
                end
            end
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q      <= '0;
            frame_seen_q <= 1'b0;
            k_q          <= '0;
            crc_q        <= '0;
            shift_q      <= '0;
            cnt_q        <= '0;
            Temp_Raw     <= '0;
            Hum_Raw      <= '0;
            Error_Flag   <= ERR_NONE;
        end else begin
            cnt_q <= i2c.Output_Received_Counter;

            if ((state_d != state_q) || activity)                   timer_q <= '0;
            else if (state_q inside {S_CMD_WAIT, S_MEAS_WAIT, S_RD}) timer_q <= timer_q + TW'(1);

            if (state_q == S_CMD_REQ)                           frame_seen_q <= 1'b0;
            else if ((state_q == S_CMD_WAIT) && i2c.Frames_Read) frame_seen_q <= 1'b1;

            // data bytes shift in as {T_msb, T_lsb, H_msb, H_lsb}; CRC bytes are only compared
            if (state_q == S_RD_REQ) begin
                k_q   <= '0;
                crc_q <= CRC_INIT;
            end else if ((state_q == S_RD) && byte_evt) begin
                k_q <= k_q + 3'd1;
                if ((k_q == 3'd2) || (k_q == K_LAST)) begin
                    crc_q <= CRC_INIT;
                end else begin
                    crc_q   <= crc_next;
                    shift_q <= {shift_q[23:0], i2c.Data_Received};
                end
            end

            if ((state_q == S_RD) && (state_d == S_DONE)) begin
                Temp_Raw <= shift_q[31:16];
                Hum_Raw  <= shift_q[15:0];
            end

            if ((state_q == S_IDLE) && Start) Error_Flag <= ERR_NONE;
            else if (state_d == S_ERR)        Error_Flag <= err_cause;
        end
    end
endmodule

// File: tb/tb_sht40_sequencer.sv
// Randomised bench for sht40_sequencer: stimulus pushes expected outcomes, a monitor
// compares them each time Busy falls; short wait/timeout parameters keep runs brief.
module tb_sht40_sequencer;
    import sht40_pkg::*;

    localparam int MEAS = 50;
    localparam int TO   = 300;

    typedef struct {
        logic [1:0]  flag;
        logic [15:0] temp;
        logic [15:0] hum;
        bit          valid;
        bit          crc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Start = 1'b0;
    logic        Busy, Data_Valid;
    logic [15:0] Temp_Raw, Hum_Raw;
    logic [1:0]  Error_Flag;

    sht40_sequencer_if bus ();

    sht40_sequencer #(.MEAS_WAIT_CYCLES(MEAS), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .Start      (Start),
        .i2c        (bus),
        .Busy       (Busy),
        .Temp_Raw   (Temp_Raw),
        .Hum_Raw    (Hum_Raw),
        .Data_Valid (Data_Valid),
        .Error_Flag (Error_Flag)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          pr_count = 0;
    int          orc = 0;
    logic [15:0] model_temp = '0;
    logic [15:0] model_hum  = '0;
    exp_t        exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // CRC as polynomial long division of the init-adjusted word times x^8
    function automatic logic [7:0] ref_crc(input logic [15:0] w);
        logic [23:0] r;
        r = {w ^ 16'hFF00, 8'h00};
        for (int i = 23; i >= 8; i--)
            if (r[i]) r = r ^ (24'h131 << (i - 8));
        return r[7:0];
    endfunction

    function automatic logic [47:0] mk(input logic [15:0] t, input logic [15:0] h,
                                       input logic [7:0] xt, input logic [7:0] xh);
        return {t, ref_crc(t) ^ xt, h, ref_crc(h) ^ xh};
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(Busy), 0);
        chk({tag, "_pr"}, 32'(bus.Processor_Ready), 0);
        chk({tag, "_rnw"}, 32'(bus.Read_Not_Write), 0);
        chk({tag, "_crcerr"}, 32'(bus.CRC_Error), 0);
        chk({tag, "_dv"}, 32'(Data_Valid), 0);
        chk({tag, "_temp"}, 32'(Temp_Raw), 0);
        chk({tag, "_hum"}, 32'(Hum_Raw), 0);
        chk({tag, "_errflag"}, 32'(Error_Flag), 0);
        chk({tag, "_cmd"}, 32'(bus.Command_Data_Frames), 32'hFD);
        chk({tag, "_writes"}, 32'(bus.I2c_Writes), 1);
        chk({tag, "_reads"}, 32'(bus.SHT_Reads), 5);
    endtask

    task automatic run_meas(input logic [47:0] b, input int nframes, input bit extra_start,
                            input int rst_after);
        exp_t e;
        int   fail_idx, nfeed, s, n, pr0;
        bit   ok1, ok2;
        ok1      = (ref_crc(b[47:32]) == b[31:24]);
        ok2      = (ref_crc(b[23:8]) == b[7:0]);
        fail_idx = -1;
        e.valid  = 0;
        e.crc    = 0;
        e.temp   = model_temp;
        e.hum    = model_hum;
        e.flag   = ERR_NONE;
        if (nframes < 2) begin
            e.flag = ERR_TIMEOUT; nfeed = 0;
        end else if (rst_after > 0) begin
            e.temp = '0; e.hum = '0; nfeed = rst_after;
        end else if (!ok1) begin
            e.flag = ERR_CRC; e.crc = 1; fail_idx = 2; nfeed = 3;
        end else if (!ok2) begin
            e.flag = ERR_CRC; e.crc = 1; fail_idx = 5; nfeed = 6;
        end else begin
            e.valid = 1; e.temp = b[47:32]; e.hum = b[23:8]; nfeed = 6;
        end
        exp_q.push_back(e);
        model_temp = e.temp;
        model_hum  = e.hum;
        pr0        = pr_count;
        s          = cyc;

        tick(); Start = 1'b1;
        tick(); Start = 1'b0;
        @(negedge clk);
        chk("cmd_req", 32'(bus.Processor_Ready), 1);
        chk("cmd_rnw", 32'(bus.Read_Not_Write), 0);
        chk("cmd_byte", 32'(bus.Command_Data_Frames), 32'hFD);
        chk("cmd_writes", 32'(bus.I2c_Writes), 1);
        chk("busy_on", 32'(Busy), 1);

        for (int f = 0; f < nframes; f++) begin
            repeat ($urandom_range(1, 4)) tick();
            bus.Frames_Read = 1'b1;
            s = cyc + 1;
            tick();
            bus.Frames_Read = 1'b0;
        end

        if (nframes < 2) begin
            n = 0;
            while (Busy && n < TO + 20) begin @(negedge clk); n++; end
            chk("timeout_len", cyc - s, TO + 1);
            repeat (2) @(negedge clk);
            chk("pr_count_timeout", pr_count - pr0, 1);
            return;
        end

        if (extra_start) begin
            repeat (5) tick();
            Start = 1'b1;
            tick();
            Start = 1'b0;
        end

        n = 0;
        while (!bus.Processor_Ready && n < MEAS + 20) begin @(negedge clk); n++; end
        chk("rd_req", 32'(bus.Processor_Ready), 1);
        chk("rd_rnw", 32'(bus.Read_Not_Write), 1);
        chk("meas_wait", cyc - s, MEAS);

        for (int i = 0; i < nfeed; i++) begin
            tick();
            repeat ($urandom_range(0, 2)) tick();
            orc = (orc + 1) % 6;
            bus.Output_Received_Counter = 4'(orc);
            bus.Data_Received           = b[47 - 8*i -: 8];
            if (i == fail_idx) begin
                @(negedge clk);
                chk("crc_err_early", 32'(bus.CRC_Error), 0);
                @(negedge clk);
                chk("crc_err", 32'(bus.CRC_Error), 1);
                chk("err_flag_crc", 32'(Error_Flag), 32'(ERR_CRC));
            end
        end

        if (rst_after > 0) begin
            @(negedge clk);
            #2 rst = 1'b1;
            orc = 0;
            bus.Output_Received_Counter = 4'd0;
            #1 check_reset_outputs("midrst");
            tick(); tick();
            rst = 1'b0;
        end

        n = 0;
        while (Busy && n < 20) begin @(negedge clk); n++; end
        chk("busy_off", 32'(Busy), 0);
        repeat (2) @(negedge clk);
        chk("pr_count", pr_count - pr0, 2);
        if (extra_start) begin
            repeat (MEAS + 10) @(negedge clk);
            chk("no_restart_busy", 32'(Busy), 0);
            chk("no_restart_pr", pr_count - pr0, 2);
        end
    endtask

    initial begin : monitor
        bit   prev_busy, prev_dv, crc_seen;
        int   dv_n;
        exp_t e;
        prev_busy = 0; prev_dv = 0; crc_seen = 0; dv_n = 0;
        forever begin
            @(negedge clk);
            if (bus.Processor_Ready) pr_count++;
            if (Data_Valid) dv_n++;
            if (bus.CRC_Error) crc_seen = 1;
            if (prev_busy && !Busy) begin
                if (exp_q.size() == 0) begin
                    chk("exp_available", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_err_flag", 32'(Error_Flag), 32'(e.flag));
                    chk("sb_temp", 32'(Temp_Raw), 32'(e.temp));
                    chk("sb_hum", 32'(Hum_Raw), 32'(e.hum));
                    chk("sb_dv_count", dv_n, e.valid ? 1 : 0);
                    chk("sb_dv_last_busy", 32'(prev_dv), 32'(e.valid));
                    chk("sb_crc_error", 32'(crc_seen), 32'(e.crc));
                end
                dv_n = 0;
                crc_seen = 0;
            end
            prev_busy = Busy;
            prev_dv   = Data_Valid;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin : stimulus
        logic [15:0] t, h;
        logic [7:0]  xt, xh;
        bus.Frames_Read             = 1'b0;
        bus.Data_Received           = 8'h00;
        bus.Output_Received_Counter = 4'd0;
        #2 check_reset_outputs("reset");
        tick(); tick();
        rst = 1'b0;
        tick();

        run_meas(48'hBEEF92_BEEF92, 2, 0, 0);
        run_meas(48'hBEEF93_BEEF92, 2, 0, 0);
        run_meas(48'h123456_789ABC, 1, 0, 0);
        run_meas(mk(16'h6A3C, 16'h8F10, 8'h00, 8'h00), 2, 1, 0);
        run_meas(mk(16'h4455, 16'h6677, 8'h00, 8'h00), 2, 0, 3);
        run_meas(48'hBEEF92_BEEF92, 2, 0, 0);
        run_meas(mk(16'h0102, 16'h0304, 8'h00, 8'h5A), 2, 0, 0);

        for (int i = 0; i < 10; i++) begin
            t  = 16'($urandom);
            h  = 16'($urandom);
            xt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            xh = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run_meas(mk(t, h, xt, xh), 2, 0, 0);
        end

        repeat (5) @(negedge clk);
        chk("exp_queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
